// File: rtl/dmem_sub_word.sv
// Big-endian byte/half/word data memory with request/response handshake,
// post-reset clear engine and a registered word-wide debug read port.
module dmem_sub_word #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_BYTES),
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
  output logic                  busy
);

  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned WAW   = ADDR_WIDTH - 2;
  localparam logic [WAW-1:0] LAST_WORD = WAW'(WORDS - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [WAW-1:0]        r_clr_cnt;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] r_debug_data;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_accept;
  logic [WAW-1:0]        w_word_idx;
  logic [1:0]            w_off;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_err;
  logic [3:0]            w_lane_be;
  logic [DATA_WIDTH-1:0] w_st_word;
  logic [7:0]            w_ld_byte;
  logic [15:0]           w_ld_half;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic                  w_mem_we;
  logic [WAW-1:0]        w_mem_idx;
  logic [3:0]            w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_unused_dbg_lsb;

  assign w_accept   = req_valid && r_req_ready;
  assign w_word_idx = req_addr[ADDR_WIDTH-1:2];
  assign w_off      = req_addr[1:0];
  assign w_rd_word  = r_mem[w_word_idx];

  // Debug reads are word-granular; the byte offset bits carry no meaning.
  assign w_unused_dbg_lsb = ^debug_addr[1:0];

  // Request decode: alignment check, lane enables, replicated store data.
  always_comb begin
    w_err     = 1'b0;
    w_lane_be = 4'b0000;
    w_st_word = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_lane_be[w_off] = 1'b1;
        w_st_word        = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_err     = w_off[0];
        w_lane_be = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_word = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_err     = (w_off != 2'b00);
        w_lane_be = 4'b1111;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // Load lane select (lane 0 is the most significant byte) and extension.
  always_comb begin
    w_ld_byte = 8'h00;
    case (w_off)
      2'd0:    w_ld_byte = w_rd_word[31:24];
      2'd1:    w_ld_byte = w_rd_word[23:16];
      2'd2:    w_ld_byte = w_rd_word[15:8];
      default: w_ld_byte = w_rd_word[7:0];
    endcase
    w_ld_half = w_off[1] ? w_rd_word[15:0] : w_rd_word[31:16];
    w_ld_data = w_rd_word;
    case (req_size)
      SZ_BYTE: w_ld_data = req_unsigned ? {24'h000000, w_ld_byte}
                                        : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_ld_data = req_unsigned ? {16'h0000, w_ld_half}
                                        : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = w_rd_word;
    endcase
  end

  // Single array write port shared by the clear engine and stores.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_word_idx;
    w_mem_be    = 4'b0000;
    w_mem_wdata = w_st_word;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_cnt;
      w_mem_be    = 4'b1111;
      w_mem_wdata = '0;
    end else if (w_accept && req_we && !w_err) begin
      w_mem_we = 1'b1;
      w_mem_be = w_lane_be;
    end
  end

  // Storage array is deliberately not reset; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_mem_be[k]) begin
          r_mem[w_mem_idx][8*(3-k) +: 8] <= w_mem_wdata[8*(3-k) +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake, response and debug outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt    <= '0;
      r_req_ready  <= 1'b0;
      r_busy       <= (INIT_CLEAR != 0);
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_debug_data <= '0;
    end else begin
      r_rsp_valid  <= w_accept;
      r_rsp_err    <= w_accept && w_err;
      r_rsp_rdata  <= (w_accept && !req_we && !w_err) ? w_ld_data : '0;
      r_debug_data <= r_mem[debug_addr[ADDR_WIDTH-1:2]];
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + WAW'(1);
          if (r_clr_cnt == LAST_WORD) begin
            r_state     <= ST_READY;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign debug_data = r_debug_data;

endmodule
